light_dispatch: RTL
===================

LIGHT_DISPATCH -- requirements
Module: light_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning result-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter WAIT_LIMIT, default 64, meaning max cycles in WAIT before abort.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream triangle offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the offered triangle.
REQ-007 SHALL have port in_triangle  input  144  three fp16 xyz vertices, v0 in [143:96].
REQ-008 SHALL have port in_rgb  input  24  base colour {r,g,b}.
REQ-009 SHALL have port lt_en  output  1  one-cycle start pulse to the lighting stage.
REQ-010 SHALL have port lt_triangle  output  144  held triangle driven to the lighting stage.
REQ-011 SHALL have port lt_rgb  output  24  held base colour driven to the lighting stage.
REQ-012 SHALL have port lt_valid  input  1  lighting-stage done pulse.
REQ-013 SHALL have port lt_illuminated  input  1  lighting-stage visibility, sampled only with lt_valid.
REQ-014 SHALL have port lt_shaded_rgb  input  24  lighting-stage colour, sampled only with lt_valid.
REQ-015 SHALL have ports out_valid output 1, out_ready input 1, out_triangle output 144, out_rgb output 24: downstream queue head.
REQ-016 SHALL have port timeout_err  output  1  sticky flag, set on any WAIT abort.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-018 in_ready SHALL be 1 only in IDLE with queue occupancy < FIFO_DEPTH (slot reserved for the single in-flight triangle).
REQ-019 On in_valid&in_ready: capture in_triangle/in_rgb into hold registers, IDLE->ISSUE.
REQ-020 ISSUE SHALL assert lt_en for exactly one cycle, then ->WAIT; lt_en SHALL be 0 in all other states.
REQ-021 lt_triangle/lt_rgb SHALL stay constant from capture until return to IDLE.
REQ-022 In WAIT with lt_valid=1: if lt_illuminated=1 push {hold triangle, lt_shaded_rgb} to queue, else drop; ->IDLE either way.
REQ-023 In WAIT, a cycle counter SHALL count from 0; on reaching WAIT_LIMIT without lt_valid, set timeout_err, drop, ->IDLE.
REQ-024 lt_valid outside WAIT SHALL be ignored.
REQ-025 Accept at edge T => lt_en high in cycle T+1; push at edge of lt_valid cycle V => out_valid high from V+1; in_ready may reassert in V+1.
REQ-026 Queue SHALL be first-word-fall-through: out_valid = occupancy!=0; pop on out_valid&out_ready.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; pointers wrap modulo FIFO_DEPTH.
REQ-028 Push SHALL never occur when full (guaranteed by REQ-018); pop when empty SHALL be ignored.
REQ-029 out_triangle/out_rgb SHALL be stable while out_valid&!out_ready.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, queue empty, counters 0, and in_ready=0, lt_en=0, out_valid=0, timeout_err=0, hold registers/lt_triangle/lt_rgb/out_triangle/out_rgb=0.
REQ-031 Reset mid-ISSUE/WAIT SHALL abandon the in-flight triangle without push; first cycle after release in_ready=1.

Configuration
REQ-032 Macro LIGHT_DISPATCH_STATS_EN SHALL, when defined, add output cull_count (16 bits, reset 0) incrementing on every lt_valid with lt_illuminated=0 in WAIT, saturating at 16'hFFFF.
REQ-033 Without LIGHT_DISPATCH_STATS_EN, cull_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 One lit triangle, lighting model returns lt_valid 20 cycles after lt_en with illuminated=1, rgb 24'h808080 -> one lt_en pulse, out_valid 1 cycle after lt_valid, out_rgb 24'h808080, out_triangle equals input.
REQ-035 Unlit triangle (illuminated=0) -> no push, out_valid stays 0, in_ready returns next cycle; with STATS_EN cull_count=1.
REQ-036 out_ready=0, push 4 lit triangles at FIFO_DEPTH=4 -> in_ready held 0 after fourth push; one pop -> in_ready=1 next cycle; order preserved.
REQ-037 lt_valid never returned, WAIT_LIMIT=64 -> timeout_err=1 after 64 WAIT cycles, back to IDLE, no push, sticky until reset.
REQ-038 rst_n asserted 5 cycles into WAIT, then spurious lt_valid after release -> ignored, all outputs at reset values, queue empty.
REQ-039 Push and pop in same cycle at occupancy 2 -> occupancy stays 2, head advances to next entry.

Source files
------------

// File: rtl/light_dispatch.sv
// light_dispatch
// ----------------------------------------------------------------------------
// Dispatches one triangle at a time to an external lighting stage and queues
// the lit results for a downstream consumer.
//
// Flow: a triangle is accepted in IDLE and latched into hold registers. In
// ISSUE a one-cycle lt_en pulse starts the lighting stage. WAIT then waits
// for lt_valid. A lit result ({held triangle, shaded colour}) is pushed into
// a first-word-fall-through result queue. An unlit result is dropped. If no
// answer arrives within WAIT_LIMIT cycles, the triangle is abandoned and the
// sticky timeout_err flag is set.
//
// Handshake rule (in_* and out_*): a transfer happens on a rising clk edge
// where valid and ready are both 1. The producer may not withdraw data while
// its valid is high and ready is low. ready never depends combinationally on
// valid.
//
// Parameters
//   FIFO_DEPTH  result-queue entries (power of two, 2..16)
//   WAIT_LIMIT  cycles spent in WAIT before the in-flight triangle is aborted
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             upstream triangle handshake
//   in_triangle[143:0]            three fp16 xyz vertices, v0 in [143:96]
//   in_rgb[23:0]                  base colour {r,g,b}
//   lt_en                         one-cycle start pulse to the lighting stage
//   lt_triangle, lt_rgb           held triangle/colour for the lighting stage
//   lt_valid, lt_illuminated,
//   lt_shaded_rgb                 lighting-stage result (used only in WAIT)
//   out_valid/out_ready           downstream queue-head handshake
//   out_triangle, out_rgb         queue head
//   timeout_err                   sticky, set on every WAIT abort
//   cull_count[15:0]              saturating count of unlit results; present
//                                 only when LIGHT_DISPATCH_STATS_EN is defined
//   dbg_state[1:0]                current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//
// Optional feature macro: LIGHT_DISPATCH_STATS_EN
// ----------------------------------------------------------------------------
module light_dispatch #(
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_LIMIT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [143:0] in_triangle,
    input  logic [23:0]  in_rgb,
    output logic         lt_en,
    output logic [143:0] lt_triangle,
    output logic [23:0]  lt_rgb,
    input  logic         lt_valid,
    input  logic         lt_illuminated,
    input  logic [23:0]  lt_shaded_rgb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [143:0] out_triangle,
    output logic [23:0]  out_rgb,
    output logic         timeout_err,
`ifdef LIGHT_DISPATCH_STATS_EN
    output logic [15:0]  cull_count,
`endif
    output logic [1:0]   dbg_state
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int WCNT_W  = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam int ENTRY_W = 168;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state;
    logic [143:0]        hold_tri;
    logic [23:0]         hold_rgb;
    logic [WCNT_W-1:0]   wait_cnt;

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;

    logic                accept;
    logic                push;
    logic                pop;
    logic                room_next;

    always_comb begin
        // in_ready is only ever high in IDLE, so no state term is needed.
        accept     = in_valid && in_ready;
        // The full check is redundant (in_ready reserves a slot for the
        // in-flight triangle) but keeps the queue safe on its own.
        push       = (state == S_WAIT) && lt_valid && lt_illuminated && (count != DEPTH_C);
        pop        = out_valid && out_ready;
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
        // in_ready is registered, so it is computed from the occupancy the
        // queue will have after this edge.
        room_next  = (count_next < DEPTH_C);
    end

    // Dispatch FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            hold_tri    <= '0;
            hold_rgb    <= '0;
            wait_cnt    <= '0;
            lt_en       <= 1'b0;
            in_ready    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        hold_tri <= in_triangle;
                        hold_rgb <= in_rgb;
                        lt_en    <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= S_ISSUE;
                    end else begin
                        in_ready <= room_next;
                    end
                end
                S_ISSUE: begin
                    lt_en    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A result on the last allowed cycle still wins over abort.
                    if (lt_valid) begin
                        in_ready <= room_next;
                        state    <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        in_ready    <= room_next;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                default: begin
                    lt_en    <= 1'b0;
                    in_ready <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Result queue: first-word-fall-through, pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {hold_tri, lt_shaded_rgb};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

`ifdef LIGHT_DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cull_count <= 16'd0;
        end else if ((state == S_WAIT) && lt_valid && !lt_illuminated &&
                     (cull_count != 16'hFFFF)) begin
            cull_count <= cull_count + 16'd1;
        end
    end
`endif

    assign out_valid               = (count != '0);
    assign {out_triangle, out_rgb} = mem[rd_ptr];
    assign lt_triangle             = hold_tri;
    assign lt_rgb                  = hold_rgb;
    assign dbg_state               = state;

endmodule
